// File: rtl/eaglesong_pkg.sv
// Shared constants, FSM encoding and rotate helper for the Eaglesong
// circulant-mix datapath.
package eaglesong_pkg;

  localparam int EAGLESONG_NUM_WORDS      = 16;
  localparam int EAGLESONG_WORD_WIDTH     = 32;
  localparam int EAGLESONG_STATE_WIDTH    = 512;
  localparam int EAGLESONG_COEFS_PER_WORD = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } es_state_e;

  // A doubled copy makes the circular shift a plain slice, so an amount
  // of zero falls out naturally as the identity.
  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] d;
    d = {x, x} << n;
    return d[63:32];
  endfunction

endpackage

// File: rtl/eaglesong_coefficients.sv
// Eaglesong circulant rotation amounts, three per state word (48 entries).
module eaglesong_coefficients (
  input  logic [5:0] index,
  output logic [4:0] coef
);

  always_comb begin
    coef = 5'd0;
    case (index)
      6'd0:  coef = 5'd0;   6'd1:  coef = 5'd2;   6'd2:  coef = 5'd4;
      6'd3:  coef = 5'd0;   6'd4:  coef = 5'd13;  6'd5:  coef = 5'd22;
      6'd6:  coef = 5'd0;   6'd7:  coef = 5'd4;   6'd8:  coef = 5'd19;
      6'd9:  coef = 5'd0;   6'd10: coef = 5'd3;   6'd11: coef = 5'd14;
      6'd12: coef = 5'd0;   6'd13: coef = 5'd27;  6'd14: coef = 5'd31;
      6'd15: coef = 5'd0;   6'd16: coef = 5'd3;   6'd17: coef = 5'd8;
      6'd18: coef = 5'd0;   6'd19: coef = 5'd17;  6'd20: coef = 5'd26;
      6'd21: coef = 5'd0;   6'd22: coef = 5'd3;   6'd23: coef = 5'd12;
      6'd24: coef = 5'd0;   6'd25: coef = 5'd18;  6'd26: coef = 5'd22;
      6'd27: coef = 5'd0;   6'd28: coef = 5'd12;  6'd29: coef = 5'd18;
      6'd30: coef = 5'd0;   6'd31: coef = 5'd4;   6'd32: coef = 5'd7;
      6'd33: coef = 5'd0;   6'd34: coef = 5'd4;   6'd35: coef = 5'd31;
      6'd36: coef = 5'd0;   6'd37: coef = 5'd12;  6'd38: coef = 5'd27;
      6'd39: coef = 5'd0;   6'd40: coef = 5'd7;   6'd41: coef = 5'd17;
      6'd42: coef = 5'd0;   6'd43: coef = 5'd7;   6'd44: coef = 5'd8;
      6'd45: coef = 5'd0;   6'd46: coef = 5'd1;   6'd47: coef = 5'd13;
      default: coef = 5'd0;
    endcase
  end

endmodule

// File: rtl/eaglesong_word_mix.sv
// Combinational word mixer: XOR of three circular left rotations of one word.
module eaglesong_word_mix
  import eaglesong_pkg::*;
(
  input  logic [31:0] word_in,
  input  logic [4:0]  coef0,
  input  logic [4:0]  coef1,
  input  logic [4:0]  coef2,
  output logic [31:0] word_out
);

  always_comb begin
    word_out = rotl32(word_in, coef0) ^ rotl32(word_in, coef1) ^ rotl32(word_in, coef2);
  end

endmodule

// File: rtl/eaglesong_circulant_stage.sv
// Sequential circulant-mix stage: mixes one 32-bit word of a 512-bit state
// per cycle, with valid/ready handshakes on input and output.
module eaglesong_circulant_stage
  import eaglesong_pkg::*;
#(
  parameter int NUM_WORDS  = EAGLESONG_NUM_WORDS,
  parameter int WORD_WIDTH = EAGLESONG_WORD_WIDTH
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_WORDS*WORD_WIDTH-1:0]   state_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_WORDS*WORD_WIDTH-1:0]   state_out,
  output logic                              busy
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high. in_ready is high only in IDLE; out_valid is high only in DONE
  // and state_out is held stable until the transfer completes.

  es_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [NUM_WORDS*WORD_WIDTH-1:0] work_q, work_d;

  logic [5:0]  idx0, idx1, idx2;
  logic [4:0]  coef0, coef1, coef2;
  logic [31:0] cur_word, mix_word;

  always_comb begin
    idx0 = {2'b00, cnt_q} * 6'd3;
    idx1 = idx0 + 6'd1;
    idx2 = idx0 + 6'd2;
    cur_word = work_q[{cnt_q, 5'b00000} +: 32];
  end

  eaglesong_coefficients u_coef0 (.index(idx0), .coef(coef0));
  eaglesong_coefficients u_coef1 (.index(idx1), .coef(coef1));
  eaglesong_coefficients u_coef2 (.index(idx2), .coef(coef2));

  eaglesong_word_mix u_mix (
    .word_in  (cur_word),
    .coef0    (coef0),
    .coef1    (coef1),
    .coef2    (coef2),
    .word_out (mix_word)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d  = state_in;
          cnt_d   = 4'd0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        work_d[{cnt_q, 5'b00000} +: 32] = mix_word;
        if (cnt_q == 4'd15) begin
          cnt_d   = 4'd0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset clears the working register so an abandoned partial result never
  // appears on state_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_RUN);
    state_out = work_q;
  end

endmodule

// File: tb/tb_eaglesong_circulant_stage.sv
// Directed bench for eaglesong_circulant_stage with hand-computed vectors.
module tb_eaglesong_circulant_stage;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [511:0] state_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [511:0] state_out;
  logic         busy;

  int total = 0;
  int bad   = 0;

  eaglesong_circulant_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [511:0] s);
    state_in = s;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Returns cycles from the acceptance cycle up to and including the first
  // out_valid cycle, and how many of those cycles had busy high.
  task automatic wait_done(output int lat, output int bcnt);
    int cyc;
    cyc  = 0;
    bcnt = 0;
    while (!out_valid && cyc < 40) begin
      if (busy) bcnt++;
      tick();
      cyc++;
    end
    lat = cyc + 1;
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ov_low"}, {511'd0, out_valid}, 512'd0);
    check({tag, "_in_ready"}, {511'd0, in_ready}, 512'd1);
  endtask

  logic [511:0] s, e, ones, s_a, s_b, e_a, e_b;
  int lat, bcnt;

  initial begin
    ones = '1;

    // reset state
    reset = 1'b1;
    tick();
    tick();
    check("rst_in_ready",  {511'd0, in_ready},  512'd1);
    check("rst_out_valid", {511'd0, out_valid}, 512'd0);
    check("rst_busy",      {511'd0, busy},      512'd0);
    check("rst_state_out", state_out,           512'd0);
    reset = 1'b0;
    tick();

    // 1: all-zero state, latency and busy duration
    start('0);
    wait_done(lat, bcnt);
    check("t1_latency", 512'(lat), 512'd17);
    check("t1_busy_cycles", 512'(bcnt), 512'd16);
    check("t1_busy_done", {511'd0, busy}, 512'd0);
    check("t1_data", state_out, 512'd0);
    handshake("t1");

    // 2: word0 = 1, coefs 0,2,4
    s = '0; s[0 +: 32] = 32'h0000_0001;
    e = '0; e[0 +: 32] = 32'h0000_0015;
    start(s);
    wait_done(lat, bcnt);
    check("t2_latency", 512'(lat), 512'd17);
    check("t2_data", state_out, e);
    handshake("t2");

    // 3: word4 (coefs 0,27,31) and word15 (coefs 0,1,13)
    s = '0; s[128 +: 32] = 32'h0000_0001; s[480 +: 32] = 32'h0000_0001;
    e = '0; e[128 +: 32] = 32'h8800_0001; e[480 +: 32] = 32'h0000_2003;
    start(s);
    wait_done(lat, bcnt);
    check("t3_latency", 512'(lat), 512'd17);
    check("t3_data", state_out, e);
    handshake("t3");

    // 4: all ones, output back-pressure for 5 cycles
    start(ones);
    wait_done(lat, bcnt);
    check("t4_latency", 512'(lat), 512'd17);
    check("t4_data", state_out, ones);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_ov", {511'd0, out_valid}, 512'd1);
      check("t4_hold_ir", {511'd0, in_ready}, 512'd0);
      check("t4_hold_data", state_out, ones);
    end
    handshake("t4");

    // 5: in_valid held through RUN with a different state
    s_a = '0; s_a[0 +: 32] = 32'h0000_0001;
    e_a = '0; e_a[0 +: 32] = 32'h0000_0015;
    s_b = '0; s_b[480 +: 32] = 32'h0000_0001;
    e_b = '0; e_b[480 +: 32] = 32'h0000_2003;
    state_in = s_a;
    in_valid = 1'b1;
    tick();
    state_in = s_b;
    wait_done(lat, bcnt);
    check("t5_latency", 512'(lat), 512'd17);
    check("t5_data_a", state_out, e_a);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t5_no_same_cycle_accept", {511'd0, busy}, 512'd0);
    check("t5_in_ready", {511'd0, in_ready}, 512'd1);
    tick();
    in_valid = 1'b0;
    check("t5_second_accept", {511'd0, busy}, 512'd1);
    wait_done(lat, bcnt);
    check("t5_data_b", state_out, e_b);
    handshake("t5");

    // 6: reset at RUN cycle 8, then a clean transaction
    start(ones);
    for (int i = 0; i < 8; i++) tick();
    check("t6_busy_mid", {511'd0, busy}, 512'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_ov", {511'd0, out_valid}, 512'd0);
    check("t6_rst_ir", {511'd0, in_ready}, 512'd1);
    check("t6_rst_data", state_out, 512'd0);
    s = '0; s[128 +: 32] = 32'h0000_0001;
    e = '0; e[128 +: 32] = 32'h8800_0001;
    start(s);
    wait_done(lat, bcnt);
    check("t6_latency", 512'(lat), 512'd17);
    check("t6_data", state_out, e);
    handshake("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
